// File: rtl/wb_ram_slave.sv
// Wishbone B4 pipelined RAM responder: fixed-latency in-order acks and a stall bounded by an outstanding counter.
// Optional WB_RAM_SLAVE_STALL_INJECT_EN adds LFSR-driven random stalls for master stress testing.

module wb_ram_lane #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdat,
  output logic [7:0]    o_rdat
);
  logic [7:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk_i)
    if (i_we) r_mem[i_addr] <= i_wdat;

  // Read is taken before the write edge, so the response carries the pre-write word.
  assign o_rdat = r_mem[i_addr];
endmodule

module wb_ram_slave #(
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o
);
  localparam int NUM_LANES = 4;
  localparam int CW        = $clog2(MAX_OUTSTANDING + 1);

  logic                              w_accept;
  logic                              w_ack;
  logic                              w_cnt_full;
  logic [DEPTH_LOG2-1:0]             w_idx;
  logic [NUM_LANES-1:0][7:0]         w_lane_rdat;
  logic [31:0]                       w_s0_dat;
  logic                              w_unused_adr;

  logic [LATENCY-1:0]                r_vld_pipe;
  logic [LATENCY-1:0][31:0]          r_dat_pipe;
  logic [CW-1:0]                     r_cnt;
  logic [31:0]                       r_dat_hold;

  assign w_accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign w_idx        = wb_adr_i[DEPTH_LOG2+1:2];
  assign w_unused_adr = ^{wb_adr_i[31:DEPTH_LOG2+2], wb_adr_i[1:0]};

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    wb_ram_lane #(.AW(DEPTH_LOG2)) u_lane (
      .clk_i  (clk_i),
      .i_we   (w_accept & wb_we_i & wb_sel_i[n]),
      .i_addr (w_idx),
      .i_wdat (wb_dat_i[8*n +: 8]),
      .o_rdat (w_lane_rdat[n])
    );
  end

  assign w_s0_dat = wb_we_i ? 32'h0 : w_lane_rdat;

  // Dropping cyc aborts everything in flight; writes already committed stay.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_vld_pipe <= '0;
    end else if (!wb_cyc_i) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_dat_pipe <= '0;
    end else begin
      if (w_accept) r_dat_pipe[0] <= w_s0_dat;
      for (int i = 1; i < LATENCY; i++) r_dat_pipe[i] <= r_dat_pipe[i-1];
    end

  assign w_ack = r_vld_pipe[LATENCY-1] & wb_cyc_i;

  // An ack and an accept in the same cycle cancel; the counter still sees the retiring request.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)                   r_cnt <= '0;
    else if (!wb_cyc_i)          r_cnt <= '0;
    else if (w_accept && !w_ack) r_cnt <= r_cnt + 1'b1;
    else if (w_ack && !w_accept) r_cnt <= r_cnt - 1'b1;

  assign w_cnt_full = (r_cnt == CW'(MAX_OUTSTANDING));

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)      r_dat_hold <= '0;
    else if (w_ack) r_dat_hold <= r_dat_pipe[LATENCY-1];

  assign wb_ack_o = w_ack;
  assign wb_dat_o = w_ack ? r_dat_pipe[LATENCY-1] : r_dat_hold;

`ifdef WB_RAM_SLAVE_STALL_INJECT_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16/14/13/11.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  assign wb_stall_o = w_cnt_full | r_lfsr[0];
`else
  assign wb_stall_o = w_cnt_full;
`endif
endmodule

// File: tb/tb_wb_ram_slave.sv
// Randomized scoreboard bench for wb_ram_slave: stimulus pushes expected acks, a negedge monitor retires them.
module tb_wb_ram_slave;
  localparam int DL  = 10;
  localparam int LAT = 3;
  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
  logic        wb_ack_o, wb_stall_o;

  wb_ram_slave #(.DEPTH_LOG2(DL), .LATENCY(LAT), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] dat; } exp_t;
  exp_t        q[$];
  logic [31:0] mem [1024];
  logic [31:0] last_dat = '0;
  logic        exp_stall = 1'b0;
  int          cycle = 0;
  int          checks = 0, errors = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", nm, cycle, act, exp);
    end
  endtask

  // One bus cycle; acceptance and expected response come from the model's pending count.
  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sl, output logic acc);
    exp_t e;
    wb_cyc_i = c; wb_stb_i = s; wb_we_i = w; wb_adr_i = a; wb_dat_i = d; wb_sel_i = sl;
    exp_stall = (q.size() == MAX);
    acc = c & s & ~exp_stall;
    if (acc) begin
      e.due = cycle + LAT;
      if (w) begin
        e.dat = 32'h0;
        for (int n = 0; n < 4; n++) if (sl[n]) mem[a[11:2]][8*n +: 8] = d[8*n +: 8];
      end else begin
        e.dat = mem[a[11:2]];
      end
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    logic acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) drive(1'b1, 1'b1, w, a, d, sl, acc);
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
  endtask

  function automatic logic [31:0] rnd_adr();
    logic [9:0]  idx;
    logic [31:0] hi, lo;
    idx = ($urandom_range(0, 1) != 0 ? 10'h3F0 : 10'h000) | 10'($urandom_range(0, 15));
    hi  = $urandom() & 32'hFFFF_F000;
    lo  = $urandom() & 32'h3;
    return hi | {20'h0, idx, 2'b00} | lo;
  endfunction

  // Monitor: retires the oldest expectation whenever an ack is due or presented.
  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
      chk("rst_stall", {31'h0, wb_stall_o}, 32'h0);
      chk("rst_dat", wb_dat_o, 32'h0);
    end else begin
      logic ea;
      ea = wb_cyc_i && q.size() > 0 && q[0].due == cycle;
      chk("stall", {31'h0, wb_stall_o}, {31'h0, exp_stall});
      chk("ack", {31'h0, wb_ack_o}, {31'h0, ea});
      if (ea) begin
        chk("ack_dat", wb_dat_o, q[0].dat);
        last_dat = q[0].dat;
        void'(q.pop_front());
      end else begin
        chk("hold_dat", wb_dat_o, last_dat);
      end
      if (!wb_cyc_i) q.delete();
    end
  end

  initial begin
    logic acc;
    logic c, w;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      issue(1'b1, {20'h0, 10'(i), 2'b00}, $urandom(), 4'hF);
      issue(1'b1, {20'h0, 10'h3F0 | 10'(i), 2'b00}, $urandom(), 4'hF);
    end

    // Byte lanes, alias, read-after-write
    issue(1'b1, 32'h20, 32'h11223344, 4'hF);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    issue(1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF);
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    idle(LAT + 1);

    // Back-to-back burst of reads
    for (int i = 0; i < 4; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
    idle(LAT + 1);

    // Abort with a read in flight
    issue(1'b0, 32'h4, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
    idle(LAT + 1);

    // Asynchronous reset with a read in flight
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    rst_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b0;
    q.delete(); last_dat = '0; exp_stall = 1'b0;
    #1;
    chk("async_rst_ack", {31'h0, wb_ack_o}, 32'h0);
    chk("async_rst_stall", {31'h0, wb_stall_o}, 32'h0);
    chk("async_rst_dat", wb_dat_o, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    idle(LAT + 1);

    for (int k = 0; k < 800; k++) begin
      c = ($urandom_range(0, 29) != 0);
      w = ($urandom_range(0, 1) != 0);
      drive(c, c & ($urandom_range(0, 9) < 7), w, rnd_adr(), $urandom(), 4'($urandom_range(0, 15)), acc);
    end

    idle(LAT + 2);
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
